// File: rtl/ofd2_arb.sv
// ofd2_arb: round-robin arbiter serialising NREQ words MSB-first on D0, framed by D1.
// Optional macro OFD2_ARB_PARITY_EN appends an even-parity bit to every frame.
module ofd2_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] DATA,
    output logic [NREQ-1:0]       GNT,
    output logic                  BUSY,
    output logic                  D0,
    output logic                  D1
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = $clog2(NREQ);
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             d0_q, d0_d;
    logic             d1_q, d1_d;
`ifdef OFD2_ARB_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             found;
    logic [PW-1:0]    win;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] win_word;

    // Search upward from the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + SW'(k);
            if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
            if (!found && REQ[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) win_word = DATA[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        d0_d    = 1'b0;
        d1_d    = 1'b0;
`ifdef OFD2_ARB_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = SHIFT;
                    sh_d       = win_word;
                    cnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    busy_d     = 1'b1;
                    d1_d       = 1'b1;
                    d0_d       = win_word[WIDTH-1];
                    ptr_d      = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
`ifdef OFD2_ARB_PARITY_EN
                    par_d      = ^win_word;
`endif
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
`ifdef OFD2_ARB_PARITY_EN
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = GAP;
                end else if (cnt_q == CW'(WIDTH-1)) begin
                    cnt_d = cnt_q + 1'b1;
                    d0_d  = par_q;
                    d1_d  = 1'b1;
                end else begin
`else
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = GAP;
                end else begin
`endif
                    // Rotate so the next bit sits in the MSB.
                    sh_d  = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
                    cnt_d = cnt_q + 1'b1;
                    d0_d  = sh_q[WIDTH-2];
                    d1_d  = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
`ifdef OFD2_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
`ifdef OFD2_ARB_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign GNT  = gnt_q;
    assign BUSY = busy_q;
    assign D0   = d0_q;
    assign D1   = d1_q;

endmodule

// File: tb/tb_ofd2_arb.sv
// tb_ofd2_arb: randomized scoreboard bench for ofd2_arb.
// Grants predicted by a frame-level model; a monitor checks GNT, frames and BUSY.
module tb_ofd2_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef OFD2_ARB_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int GAPC = FLEN + 2;

    logic                  CK = 1'b0;
    logic                  RSTN = 1'b0;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] DATA;
    logic [NREQ-1:0]       GNT;
    logic                  BUSY, D0, D1;

    ofd2_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CK(CK), .RSTN(RSTN), .REQ(REQ), .DATA(DATA),
        .GNT(GNT), .BUSY(BUSY), .D0(D0), .D1(D1)
    );

    always #5 CK = ~CK;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] w;
        int               cyc;
    } exp_t;

    exp_t             sbq[$];
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    logic             pend[NREQ];
    logic [WIDTH-1:0] word[NREQ];
    int               mptr = 0;
    int               mcd = 0;
    int               last_win = -1;
    int               mode = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: a grant at most once every GAPC edges, round-robin.
    task automatic model_step();
        cyc++;
        if (!RSTN) return;
        if (mcd > 0) begin
            mcd--;
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            int c = (mptr + k) % NREQ;
            if (pend[c]) begin
                sbq.push_back('{c, word[c], cyc});
                pend[c]  = 1'b0;
                mptr     = (c + 1) % NREQ;
                mcd      = GAPC - 1;
                last_win = c;
                return;
            end
        end
    endtask

    task automatic tick();
        @(negedge CK);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
                word[i] = WIDTH'($urandom);
                if (mode == 1) pend[i] = 1'b1;
                if (mode == 2 && $urandom_range(0, 7) == 0) pend[i] = 1'b1;
            end
            REQ[i] = pend[i];
            DATA[i*WIDTH +: WIDTH] = word[i];
        end
        @(posedge CK);
        model_step();
    endtask

    task automatic run(input int m, input int n);
        mode = m;
        repeat (n) tick();
        mode = 0;
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_gnt"}, GNT, 0);
        chk({pfx, "_busy"}, BUSY, 0);
        chk({pfx, "_d0"}, D0, 0);
        chk({pfx, "_d1"}, D1, 0);
    endtask

    // Monitor: pops on every GNT, then collects the framed bits.
    initial begin
        exp_t        cur;
        logic [63:0] bits;
        int          nb;
        int          brun;
        bit          coll;
        cur  = '{0, '0, 0};
        bits = '0;
        nb   = 0;
        brun = 0;
        coll = 1'b0;
        forever begin
            @(negedge CK);
            if (!RSTN) begin
                coll = 1'b0;
                nb   = 0;
                brun = 0;
                bits = '0;
                continue;
            end
            if (GNT != '0) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL gnt_unexpected: got GNT=%b, none expected (cycle %0d)",
                             GNT, cyc);
                end else begin
                    cur = sbq.pop_front();
                    chk("gnt_onehot", GNT, 1 << cur.idx);
                    chk("gnt_cycle", cyc, cur.cyc);
                end
                coll = 1'b1;
                nb   = 0;
                bits = '0;
            end
            if (D1) begin
                bits = {bits[62:0], D0};
                nb++;
            end else begin
                if (coll) begin
                    chk("frame_len", nb, FLEN);
                    chk("frame_data", bits[FLEN-1 -: WIDTH], cur.w);
`ifdef OFD2_ARB_PARITY_EN
                    chk("frame_parity", bits[0], ^cur.w);
`endif
                    coll = 1'b0;
                end
                chk("d0_outside_frame", D0, 0);
            end
            if (BUSY) begin
                brun++;
            end else if (brun > 0) begin
                chk("busy_len", brun, FLEN + 1);
                brun = 0;
            end
        end
    end

    initial begin
        int t;
        REQ  = '0;
        DATA = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            word[i] = '0;
        end
        repeat (3) tick();
        #1 check_quiet("rst");
        #1 RSTN = 1'b1;

        pend[2] = 1'b1;
        word[2] = 8'h3C;
        run(0, 30);

        pend[3] = 1'b1;
        word[3] = 8'h07;
        run(0, 20);
        pend[3] = 1'b1;
        word[3] = 8'h03;
        run(0, 20);

        run(1, 5 * GAPC);
        run(0, NREQ * GAPC + 5);

        pend[1] = 1'b1;
        word[1] = WIDTH'($urandom);
        run(0, GAPC + 2);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        run(0, 3 * GAPC);

        run(2, 400);
        run(0, NREQ * GAPC + 5);

        last_win = -1;
        pend[0]  = 1'b1;
        word[0]  = WIDTH'($urandom);
        t = 0;
        while (last_win != 0 && t < 40) begin
            tick();
            t++;
        end
        chk("arst_grant_seen", last_win, 0);
        repeat (3) tick();
        #2 RSTN = 1'b0;
        #1 check_quiet("arst");
        sbq.delete();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        mptr = 0;
        mcd  = 0;
        tick();
        #2 RSTN = 1'b1;

        pend[0] = 1'b1;
        word[0] = 8'hA5;
        run(0, 30);

        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        run(0, GAPC + 2);
        chk("sbq_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofd2_arb.md
Name: ofd2_arb

Overview:
- Round-robin scheduler that shares the two-bit output register pair (data lane, frame lane) between NREQ requesters.
- Each requester offers a WIDTH-bit word. The block arbitrates, serialises the winner MSB-first onto D0 and frames it on D1.
- D0/D1 are registered here and feed the output flip-flop pair directly, which adds one further CK of pin latency.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, bits per word; legal range 2..32.

Ports:
- CK  input  1  system clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester request level; bit i belongs to requester i.
- DATA  input  NREQ*WIDTH  word of requester i at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- GNT  output  NREQ  one-hot, one-cycle pulse: word of requester i accepted.
- BUSY  output  1  high while in SHIFT or GAP.
- D0  output  1  serial data to output flip-flop 0.
- D1  output  1  frame strobe to output flip-flop 1; high exactly during data bits.

Behaviour:
- Reset (RSTN low, asynchronous):
  - State = IDLE; GNT = 0, BUSY = 0, D0 = 0, D1 = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - Shift register and bit counter are cleared.
  - A reset mid-frame truncates the frame immediately, with no GAP cycle.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE, on an edge with REQ != 0:
  - Winner = first set REQ bit searching upward from the pointer, wrapping modulo NREQ.
  - Load the winner's DATA slice and set the counter to 0.
  - Next state SHIFT.
  - Registered outputs: GNT = onehot(winner) for this one cycle, D1 = 1, D0 = word[WIDTH-1], BUSY = 1.
  - Pointer becomes (winner+1) mod NREQ.
- IDLE, on an edge with REQ == 0: outputs stay 0 and the pointer is unchanged.
- SHIFT:
  - Each edge shifts the register left, increments the counter and drives D0 = next bit with D1 = 1.
  - After WIDTH bits have been driven (counter == WIDTH-1), the next edge enters GAP.
  - GNT is 0 after the first cycle.
- GAP: one cycle with D0 = 0, D1 = 0, BUSY = 1; then IDLE.
- Frame timing:
  - D1 is high for exactly WIDTH consecutive cycles.
  - The earliest next GNT comes WIDTH+2 cycles after the previous GNT (IDLE is re-entered for one arbitration edge).
- REQ and DATA are sampled only on the IDLE arbitration edge.
  - A requester must hold REQ and DATA stable until it sees GNT, and may drop REQ in the GNT cycle.
  - REQ still high after GNT counts as a new request at the next IDLE edge.
  - REQ changes during SHIFT or GAP are ignored.
- Simultaneous requests: exactly one grant per frame. Fairness: a continuously requesting input waits at most NREQ-1 frames.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame.

Optional Feature:
- Macro: OFD2_ARB_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the word) is driven on D0 with D1 still 1.
  - D1 is therefore high for WIDTH+1 cycles; the minimum GNT-to-GNT spacing is WIDTH+3.
- Undefined: no parity bit is generated; timing is exactly as in Behaviour.

Test Plan:
- Reset mid-frame: WIDTH=8, RSTN dropped in the 4th data bit -> D0, D1, GNT and BUSY go to 0 asynchronously. After release with REQ=0001 and DATA0=8'hA5, the next frame is D0 = 1,0,1,0,0,1,0,1 with D1 high for 8 cycles.
- Single requester: REQ=0100, DATA2=8'h3C -> GNT=0100 for one cycle, D0 = 0,0,1,1,1,1,0,0, D1 high for 8 cycles then 0. BUSY high for 9 cycles.
- Round-robin fairness: REQ=1111 held -> grant order 0,1,2,3,0. GNT pulses spaced exactly 10 cycles apart.
- Pointer skip: after a grant to requester 1, REQ=0011 -> requester 0 is granted (search 2,3,0), the pointer becomes 1, and the next grant goes to 1.
- Late request: REQ asserted during SHIFT -> ignored until IDLE, then granted on the first IDLE edge. The D1 low gap is exactly 2 cycles (GAP + IDLE).
- With OFD2_ARB_PARITY_EN: DATA=8'h07 -> 9 framed bits, 9th bit = 1. With DATA=8'h03 the 9th bit = 0.
